// File: rtl/chunked_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : chunked_add_sub
// Brief    : Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, NZCV flags
// Revision : 1.0 - initial release
// ============================================================================
module chunked_add_sub #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int c_num_chunks = WIDTH / CHUNK;
    localparam int c_idx_w      = (c_num_chunks > 1) ? $clog2(c_num_chunks) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_num_chunks - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [c_idx_w-1:0] r_idx;

    logic [31:0]        w_base;
    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK:0]     w_chunk_sum;
    logic               w_msb_cin;
    logic [WIDTH-1:0]   w_sum_next;

    assign busy = (r_state == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_idx == c_last_idx) begin
                    w_last       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // One CHUNK-bit slice per cycle; the carry into its top bit is recovered
    // from the sum bit so the overflow flag needs no extra adder.
    assign w_base      = 32'(r_idx) * 32'(CHUNK);
    assign w_a_chunk   = r_a[w_base +: CHUNK];
    assign w_b_chunk   = r_b[w_base +: CHUNK];
    assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + (CHUNK+1)'(r_carry);
    assign w_msb_cin   = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_chunk_sum[CHUNK-1];

    always_comb begin
        w_sum_next                    = r_sum;
        w_sum_next[w_base +: CHUNK]   = w_chunk_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            done     <= 1'b0;
            S        <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_a     <= A;
                r_b     <= B ^ {WIDTH{sub}};
                r_carry <= cin ^ sub;
                r_idx   <= '0;
            end
            if (r_state == ST_RUN) begin
                r_sum   <= w_sum_next;
                r_carry <= w_chunk_sum[CHUNK];
                r_idx   <= r_idx + 1'b1;
                if (w_last) begin
                    done     <= 1'b1;
                    S        <= w_sum_next;
                    cout     <= w_chunk_sum[CHUNK];
                    overflow <= w_chunk_sum[CHUNK] ^ w_msb_cin;
                    zero     <= (w_sum_next == '0);
                    negative <= w_sum_next[WIDTH-1];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chunked_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_add_sub
// Brief    : Self-checking bench for chunked_add_sub (N=4 and N=1 instances)
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunked_add_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start16, start64, sub, cin;
    logic [63:0] A, B;
    logic        busy16, done16, cout16, ovf16, zero16, neg16;
    logic        busy64, done64, cout64, ovf64, zero64, neg64;
    logic [63:0] s16, s64;

    chunked_add_sub #(.WIDTH(64), .CHUNK(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .sub(sub), .cin(cin),
        .A(A), .B(B), .busy(busy16), .done(done16), .S(s16), .cout(cout16),
        .overflow(ovf16), .zero(zero16), .negative(neg16)
    );

    chunked_add_sub #(.WIDTH(64), .CHUNK(64)) dut64 (
        .clk(clk), .reset(reset), .start(start64), .sub(sub), .cin(cin),
        .A(A), .B(B), .busy(busy64), .done(done64), .S(s64), .cout(cout64),
        .overflow(ovf64), .zero(zero64), .negative(neg64)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        cin;
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        z;
        logic        n;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_done(input bit w);  return w ? done64 : done16; endfunction
    function automatic logic get_busy(input bit w);  return w ? busy64 : busy16; endfunction
    function automatic logic [63:0] get_s(input bit w); return w ? s64 : s16; endfunction
    function automatic logic [3:0] get_flags(input bit w);
        return w ? {cout64, ovf64, zero64, neg64} : {cout16, ovf16, zero16, neg16};
    endfunction

    // Reference: whole-word arithmetic on 65 bits, flags from sign rules.
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input logic c,
                                  output logic [63:0] r, output logic co,
                                  output logic ov, output logic z, output logic n);
        logic [64:0] full;
        if (!s) full = {1'b0, a} + {1'b0, b} + 65'(c);
        else    full = {1'b0, a} - {1'b0, b} - 65'(c);
        r  = full[63:0];
        co = s ? ~full[64] : full[64];
        ov = s ? ((a[63] != b[63]) && (r[63] != a[63]))
               : ((a[63] == b[63]) && (r[63] != a[63]));
        z  = (r == 64'd0);
        n  = r[63];
    endfunction

    task automatic launch(input bit w, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic c);
        A = a; B = b; sub = s; cin = c;
        if (w) start64 = 1'b1; else start16 = 1'b1;
        step();
        start16 = 1'b0;
        start64 = 1'b0;
        // Scramble operands so any late capture shows up in the result
        A = ~a; B = ~b; sub = ~s; cin = ~c;
    endtask

    task automatic wait_done(input bit w, input int lat0, input logic [63:0] s_before,
                             output int lat, output int busy_cnt, output int s_chg);
        lat = lat0; busy_cnt = 0; s_chg = 0;
        while (!get_done(w) && lat < 20) begin
            if (get_busy(w)) busy_cnt++;
            if (get_s(w) !== s_before) s_chg++;
            step();
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input bit w, input logic [63:0] es,
                                input logic co, input logic ov, input logic z, input logic n);
        chk({tag, ":S"}, get_s(w), es);
        chk({tag, ":flags_cvzn"}, 64'(get_flags(w)), 64'({co, ov, z, n}));
        chk({tag, ":busy_at_done"}, 64'(get_busy(w)), 64'd0);
    endtask

    task automatic run_op(input string tag, input bit w, input logic [63:0] a,
                          input logic [63:0] b, input logic s, input logic c,
                          input logic [63:0] es, input logic co, input logic ov,
                          input logic z, input logic n);
        int lat, bcnt, schg;
        logic [63:0] s_before;
        s_before = get_s(w);
        launch(w, a, b, s, c);
        wait_done(w, 1, s_before, lat, bcnt, schg);
        chk({tag, ":latency"}, 64'(lat), w ? 64'd2 : 64'd5);
        chk({tag, ":busy_cycles"}, 64'(bcnt), w ? 64'd1 : 64'd4);
        chk({tag, ":S_held"}, 64'(schg), 64'd0);
        check_result(tag, w, es, co, ov, z, n);
    endtask

    initial begin
        logic [63:0] ra, rb, es;
        logic        rs, rc, co, ov, z, n;
        int          lat, bcnt, schg, dcnt;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{64'd7, 64'd5, 1'b1, 1'b0, 64'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{64'h1234, 64'h1, 1'b0, 1'b1, 64'h1236, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{64'd5, 64'd5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{64'd5, 64'd5, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0,
                    64'h0000_0001_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; start16 = 1'b1; start64 = 1'b1; sub = 1'b0; cin = 1'b1;
        A = 64'h1; B = 64'h1;
        step(); step();
        chk("reset:busy", 64'({busy16, busy64}), 64'd0);
        chk("reset:done", 64'({done16, done64}), 64'd0);
        chk("reset:S16", s16, 64'd0);
        chk("reset:S64", s64, 64'd0);
        chk("reset:flags16", 64'(get_flags(0)), 64'd0);
        chk("reset:flags64", 64'(get_flags(1)), 64'd0);
        reset = 1'b0; start16 = 1'b0; start64 = 1'b0;
        step();
        chk("reset:no_accept", 64'({busy16, busy64, done16, done64}), 64'd0);

        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 10; i++) begin
                run_op($sformatf("vec%0d_n%0d", i, w ? 1 : 4), w[0], vecs[i].a, vecs[i].b,
                       vecs[i].sub, vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].ov,
                       vecs[i].z, vecs[i].n);
            end
        end

        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                1: rb = 64'h7FFF_FFFF_FFFF_FFFF;
                2: ra = 64'h8000_0000_0000_0000;
                3: rb = ra;
                default: ;
            endcase
            rs = 1'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rs, rc, es, co, ov, z, n);
            run_op($sformatf("rand%0d", i), (i % 4) == 3, ra, rb, rs, rc, es, co, ov, z, n);
        end

        // Ignored mid-flight start, then a start held in the done cycle
        launch(0, 64'h10, 64'h20, 1'b0, 1'b0);
        step();
        A = 64'h100; B = 64'h1; sub = 1'b1; cin = 1'b0; start16 = 1'b1;
        step();
        start16 = 1'b0;
        chk("hs:busy_ignored", 64'(busy16), 64'd1);
        wait_done(0, 3, s16, lat, bcnt, schg);
        chk("hs:first_latency", 64'(lat), 64'd5);
        check_result("hs:first", 0, 64'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        launch(0, 64'h100, 64'h1, 1'b1, 1'b0);
        chk("hs:b2b_accepted", 64'(busy16), 64'd1);
        wait_done(0, 1, 64'h30, lat, bcnt, schg);
        chk("hs:b2b_latency", 64'(lat), 64'd5);
        chk("hs:b2b_S_held", 64'(schg), 64'd0);
        check_result("hs:b2b", 0, 64'hFF, 1'b1, 1'b0, 1'b0, 1'b0);

        // Abort after chunk 2
        run_op("pre_abort", 0, 64'h1111, 64'h2222, 1'b0, 1'b0, 64'h3333, 1'b0, 1'b0, 1'b0, 1'b0);
        launch(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        step(); step(); step();
        chk("abort:busy_before", 64'(busy16), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort:busy_done", 64'({busy16, done16}), 64'd0);
        chk("abort:S", s16, 64'd0);
        chk("abort:flags", 64'(get_flags(0)), 64'd0);
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (done16 || busy16) dcnt++;
        end
        chk("abort:no_done", 64'(dcnt), 64'd0);

        run_op("n1_3p4", 1, 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
